// File: rtl/dmem_sram_bridge.sv
// ---------------------------------------------------------------------------
// dmem_sram_bridge
//
// Turns each memory-stage load/store of the MIPS pipeline into exactly one
// transaction on an SRAM-like data bus (req / addr_ok / data_ok) and stalls
// the pipeline until that transaction has completed.
//
// Ports
//   clk, rst            : clock (rising edge) and asynchronous active-low reset
//   mem_en              : M-stage instruction is a load or a store
//   mem_wen[3:0]        : byte write mask, all zeros means load
//   mem_addr            : effective byte address
//   mem_wdata           : lane-replicated store data
//   mem_excpt           : M-stage exception / address error, suppresses access
//   pipe_stall          : stall from other sources (fetch side, divider)
//   mem_rdata           : load word back to the pipeline
//   mem_stall           : holds the whole pipeline
//   data_req/wr/size/addr/wdata : bus request side
//   data_addr_ok        : bus accepted the request
//   data_data_ok        : bus finished, data_rdata valid
//   data_rdata          : bus read data
// ---------------------------------------------------------------------------
module dmem_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [3:0]        mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_excpt,
  input  logic              pipe_stall,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                req_wr_q, req_wr_d;
  logic [1:0]          req_size_q, req_size_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                acc;
  logic                cur_wr;
  logic [1:0]          cur_size;
  logic [1:0]          cur_off;
  logic [ADDR_W-1:0]   cur_addr;

  logic                req_c;
  logic                wr_c;
  logic [1:0]          size_c;
  logic [ADDR_W-1:0]   addr_c;
  logic [DATA_W-1:0]   wdata_c;
  logic                stall_c;
  logic [DATA_W-1:0]   rdata_c;

  // The low address bits are replaced by the offset derived from the mask.
  logic                unused_addr_lsbs;
  assign unused_addr_lsbs = ^mem_addr[1:0];

  assign acc = mem_en & ~mem_excpt;

  // Decode the byte mask into bus size and the low address bits.
  // Loads and illegal masks both become aligned word accesses.
  always_comb begin
    cur_wr   = |mem_wen;
    cur_size = 2'd2;
    cur_off  = 2'd0;
    case (mem_wen)
      4'b0001: begin cur_size = 2'd0; cur_off = 2'd0; end
      4'b0010: begin cur_size = 2'd0; cur_off = 2'd1; end
      4'b0100: begin cur_size = 2'd0; cur_off = 2'd2; end
      4'b1000: begin cur_size = 2'd0; cur_off = 2'd3; end
      4'b0011: begin cur_size = 2'd1; cur_off = 2'd0; end
      4'b1100: begin cur_size = 2'd1; cur_off = 2'd2; end
      default: begin cur_size = 2'd2; cur_off = 2'd0; end
    endcase
  end

  assign cur_addr = {mem_addr[ADDR_W-1:2], cur_off};

  always_comb begin
    state_d     = state_q;
    req_wr_d    = req_wr_q;
    req_size_d  = req_size_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;

    req_c   = 1'b0;
    wr_c    = req_wr_q;
    size_c  = req_size_q;
    addr_c  = req_addr_q;
    wdata_c = req_wdata_q;
    stall_c = 1'b0;
    rdata_c = rdata_q;

    case (state_q)
      ST_IDLE: begin
        req_c   = acc;
        stall_c = acc;
        if (acc) begin
          // First request cycle comes straight from the inputs; the copy
          // keeps the fields stable while the bus withholds addr_ok.
          wr_c        = cur_wr;
          size_c      = cur_size;
          addr_c      = cur_addr;
          wdata_c     = mem_wdata;
          req_wr_d    = cur_wr;
          req_size_d  = cur_size;
          req_addr_d  = cur_addr;
          req_wdata_d = mem_wdata;
          state_d     = data_addr_ok ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        // Once raised, the request is held even if mem_excpt appears.
        req_c   = 1'b1;
        stall_c = acc;
        if (data_addr_ok) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        stall_c = acc & ~data_data_ok;
        if (data_data_ok) begin
          rdata_c = data_rdata;
          rdata_d = data_rdata;
          // If the pipeline is still held, park in DONE so the same
          // instruction sitting in M does not issue a second access.
          state_d = pipe_stall ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        if (!pipe_stall) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // While rst is low every output is forced to zero, including the IDLE
  // cycle paths that would otherwise follow mem_en combinationally.
  assign data_req   = rst & req_c;
  assign data_wr    = rst & wr_c;
  assign data_size  = rst ? size_c  : 2'd0;
  assign data_addr  = rst ? addr_c  : '0;
  assign data_wdata = rst ? wdata_c : '0;
  assign mem_stall  = rst & stall_c;
  assign mem_rdata  = rst ? rdata_c : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_wr_q    <= 1'b0;
      req_size_q  <= 2'd0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_wr_q    <= req_wr_d;
      req_size_q  <= req_size_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// ---------------------------------------------------------------------------
// tb_dmem_sram_bridge
//
// Directed vectors drive one memory-stage instruction at a time against a
// small configurable bus slave. A transaction-level model (has the request
// been raised / accepted / completed for the current instruction, and what
// was the last returned word) predicts the bridge outputs every cycle; each
// vector also carries hand-computed totals checked when the vector retires.
// ---------------------------------------------------------------------------
module tb_dmem_sram_bridge;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_excpt;
  logic        pipe_stall;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  dmem_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_excpt    (mem_excpt),
    .pipe_stall   (pipe_stall),
    .mem_rdata    (mem_rdata),
    .mem_stall    (mem_stall),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  // ---------------- bus slave: addr_ok after aw request cycles, data_ok dw
  // cycles after the accepted request's following cycle
  int          aw_cfg;
  int          dw_cfg;
  logic [31:0] rd_cfg;
  logic        s_pend;
  int          s_wcnt;
  int          s_dcnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_pend <= 1'b0;
      s_wcnt <= 0;
      s_dcnt <= 0;
    end else if (s_pend) begin
      if (data_data_ok) begin
        s_pend <= 1'b0;
        s_dcnt <= 0;
      end else begin
        s_dcnt <= s_dcnt + 1;
      end
    end else if (data_req && data_addr_ok) begin
      s_pend <= 1'b1;
      s_wcnt <= 0;
      s_dcnt <= 0;
    end else if (data_req) begin
      s_wcnt <= s_wcnt + 1;
    end
  end

  assign data_addr_ok = !s_pend && (s_wcnt >= aw_cfg);
  assign data_data_ok = s_pend && (s_dcnt >= dw_cfg);
  assign data_rdata   = data_data_ok ? rd_cfg : 32'h0BAD_F00D;

  // ---------------- vectors
  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        excpt;
    int          excpt_at;
    int          aw;
    int          dw;
    logic [31:0] rd;
    int          ps;
    int          e_req;
    int          e_stall;
    int          e_wr;
    int          e_size;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t        vecs [10];
  vec_t        cur;
  vec_t        rst_vec;
  vec_t        idle_vec;
  int          instr_id;
  logic        timed_out;

  // ---------------- model / compare state (owned by the compare process)
  int          n_checks = 0;
  int          n_errors = 0;
  vec_t        act;
  int          seen_id = 0;
  int          done_id = 0;
  logic        m_seen;
  logic        m_acc;
  logic [31:0] m_last;
  int          tx_req, tx_stall;
  logic        tx_first;
  logic        tx_wr;
  logic [1:0]  tx_size;
  logic [31:0] tx_addr, tx_wdata, tx_rd;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  // Bus fields as the mask rules describe them: one set bit is a byte at
  // that lane, an aligned contiguous pair is a half, anything else a word.
  function automatic void model_fields(input logic [3:0] wen, input logic [31:0] addr,
                                       output logic wr, output logic [1:0] size,
                                       output logic [31:0] a);
    int n;
    int lo;
    n  = $countones(wen);
    lo = 0;
    for (int i = 3; i >= 0; i--) if (wen[i]) lo = i;
    wr   = (n != 0);
    size = 2'd2;
    a    = {addr[31:2], 2'b00};
    if (n == 1) begin
      size    = 2'd0;
      a[1:0]  = lo[1:0];
    end else if (n == 2 && (lo == 0 || lo == 2) && wen[lo+1]) begin
      size    = 2'd1;
      a[1:0]  = lo[1:0];
    end
  endfunction

  always @(negedge clk) begin
    logic        acc;
    logic        e_req;
    logic        e_stall;
    logic [31:0] e_rd;
    logic        fw;
    logic [1:0]  fs;
    logic [31:0] fa;

    if (instr_id != seen_id) begin
      if (seen_id > 0) begin
        $display("tx %0d: req_cycles=%0d stall_cycles=%0d wr=%0d size=%0d addr=0x%08h rdata=0x%08h",
                 seen_id, tx_req, tx_stall, tx_wr, tx_size, tx_addr, tx_rd);
        chk("no_timeout", {31'd0, timed_out}, 32'd0);
        if (act.e_req >= 0)   chk("req_cycles", tx_req, act.e_req);
        if (act.e_stall >= 0) chk("stall_cycles", tx_stall, act.e_stall);
        if (act.e_size >= 0) begin
          chk("tx_wr", {31'd0, tx_wr}, act.e_wr);
          chk("tx_size", {30'd0, tx_size}, act.e_size);
          chk("tx_addr", tx_addr, act.e_addr);
          chk("tx_wdata", tx_wdata, act.e_wdata);
        end
        if (act.chk_rd) chk("rdata_at_ok", tx_rd, act.e_rd);
      end
      act      = cur;
      seen_id  = instr_id;
      tx_req   = 0;
      tx_stall = 0;
      tx_first = 1'b1;
      tx_wr    = 1'b0;
      tx_size  = 2'd0;
      tx_addr  = 32'd0;
      tx_wdata = 32'd0;
      tx_rd    = 32'd0;
      m_seen   = 1'b0;
      m_acc    = 1'b0;
    end

    if (!rst) begin
      chk("rst_req", {31'd0, data_req}, 32'd0);
      chk("rst_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_rdata", mem_rdata, 32'd0);
      chk("rst_wr", {31'd0, data_wr}, 32'd0);
      chk("rst_size", {30'd0, data_size}, 32'd0);
      chk("rst_addr", data_addr, 32'd0);
      chk("rst_wdata", data_wdata, 32'd0);
      m_seen = 1'b0;
      m_acc  = 1'b0;
      m_last = 32'd0;
    end else begin
      acc     = mem_en && !mem_excpt;
      e_req   = !m_acc && (done_id != seen_id) && (acc || m_seen);
      e_stall = acc && (done_id != seen_id) && !(m_acc && data_data_ok);
      e_rd    = (m_acc && data_data_ok) ? data_rdata : m_last;
      chk("data_req", {31'd0, data_req}, {31'd0, e_req});
      chk("mem_stall", {31'd0, mem_stall}, {31'd0, e_stall});
      chk("mem_rdata", mem_rdata, e_rd);
      if (e_req) begin
        model_fields(mem_wen, mem_addr, fw, fs, fa);
        chk("data_wr", {31'd0, data_wr}, {31'd0, fw});
        chk("data_size", {30'd0, data_size}, {30'd0, fs});
        chk("data_addr", data_addr, fa);
        chk("data_wdata", data_wdata, mem_wdata);
      end
      tx_req   += data_req ? 1 : 0;
      tx_stall += mem_stall ? 1 : 0;
      if (tx_first && data_req) begin
        tx_first = 1'b0;
        tx_wr    = data_wr;
        tx_size  = data_size;
        tx_addr  = data_addr;
        tx_wdata = data_wdata;
      end
      if (m_acc && data_data_ok) tx_rd = mem_rdata;
      if (e_req) m_seen = 1'b1;
      if (m_acc && data_data_ok) begin
        m_acc   = 1'b0;
        done_id = seen_id;
        m_last  = data_rdata;
      end else if (e_req && data_addr_ok) begin
        m_acc = 1'b1;
      end
    end
  end

  // ---------------- stimulus
  // Called at the start of a cycle; returns at the start of the cycle in
  // which the next instruction occupies M.
  task automatic run_vec(input vec_t v);
    int cyc;
    cur        = v;
    instr_id   = instr_id + 1;
    mem_en     = v.en;
    mem_wen    = v.wen;
    mem_addr   = v.addr;
    mem_wdata  = v.wdata;
    mem_excpt  = v.excpt;
    pipe_stall = (v.ps > 0);
    aw_cfg     = v.aw;
    dw_cfg     = v.dw;
    rd_cfg     = v.rd;
    if (!v.en || v.excpt) begin
      repeat (3) begin @(posedge clk); #1; end
    end else begin
      cyc = 0;
      while (done_id != instr_id && cyc < 60) begin
        @(posedge clk); #1;
        cyc++;
        if (cyc == v.excpt_at) mem_excpt = 1'b1;
      end
      if (done_id != instr_id) timed_out = 1'b1;
      if (v.ps > 0) begin
        repeat (v.ps - 1) begin @(posedge clk); #1; end
        pipe_stall = 1'b0;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //          en    wen      addr          wdata         ex  at  aw dw rd            ps  req st wr sz e_addr        e_wdata       crd   e_rd
    vecs[0] = '{1'b1, 4'b0000, 32'h1000_0004, 32'h0000_0000, 1'b0, -1, 0, 0, 32'hDEAD_BEEF, 0, 1, 1, 0, 2, 32'h1000_0004, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 4'b0100, 32'h0000_2003, 32'h00AB_0000, 1'b0, -1, 3, 1, 32'h0000_0000, 0, 4, 5, 1, 0, 32'h0000_2002, 32'h00AB_0000, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 4'b1100, 32'h0000_3002, 32'h1234_0000, 1'b0, -1, 0, 0, 32'h0000_0000, 0, 1, 1, 1, 1, 32'h0000_3002, 32'h1234_0000, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 4'b0000, 32'h0000_4000, 32'h0000_0000, 1'b1, -1, 0, 0, 32'h0000_0000, 0, 0, 0, -1, -1, 32'h0, 32'h0, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 4'b0000, 32'h0000_5000, 32'h0000_0000, 1'b0, -1, 0, 2, 32'hA5A5_A5A5, 3, 1, 3, 0, 2, 32'h0000_5000, 32'h0000_0000, 1'b1, 32'hA5A5_A5A5};
    vecs[5] = '{1'b1, 4'b1000, 32'h0000_4001, 32'hAB00_0000, 1'b0, -1, 1, 0, 32'h0000_0000, 0, 2, 2, 1, 0, 32'h0000_4003, 32'hAB00_0000, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 4'b0101, 32'h0000_7006, 32'h1122_3344, 1'b0, -1, 0, 0, 32'h0000_0000, 0, 1, 1, 1, 2, 32'h0000_7004, 32'h1122_3344, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 4'b0000, 32'h0000_6000, 32'h0000_0000, 1'b0,  1, 2, 1, 32'h55AA_55AA, 0, 3, 1, 0, 2, 32'h0000_6000, 32'h0000_0000, 1'b1, 32'h55AA_55AA};
    vecs[8] = '{1'b1, 4'b0011, 32'h0000_8001, 32'h0000_BEEF, 1'b0, -1, 0, 0, 32'h0F0F_0F0F, 0, 1, 1, 1, 1, 32'h0000_8000, 32'h0000_BEEF, 1'b1, 32'h0F0F_0F0F};
    vecs[9] = '{1'b1, 4'b0000, 32'h0000_9008, 32'h0000_0000, 1'b0, -1, 1, 0, 32'h1234_5678, 0, 2, 2, 0, 2, 32'h0000_9008, 32'h0000_0000, 1'b1, 32'h1234_5678};
    rst_vec  = '{1'b1, 4'b0000, 32'h0000_A000, 32'h0, 1'b0, -1, 0, 5, 32'h0, 0, -1, -1, -1, -1, 32'h0, 32'h0, 1'b0, 32'h0};
    idle_vec = '{1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, -1, 0, 0, 32'h0, 0, -1, -1, -1, -1, 32'h0, 32'h0, 1'b0, 32'h0};

    cur        = idle_vec;
    instr_id   = 0;
    timed_out  = 1'b0;
    rst        = 1'b0;
    mem_en     = 1'b0;
    mem_wen    = 4'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_excpt  = 1'b0;
    pipe_stall = 1'b0;
    aw_cfg     = 0;
    dw_cfg     = 0;
    rd_cfg     = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset while the bus is in its data phase, with mem_en still high.
    cur       = rst_vec;
    instr_id  = instr_id + 1;
    mem_en    = 1'b1;
    mem_wen   = 4'b0000;
    mem_addr  = rst_vec.addr;
    mem_wdata = 32'h0;
    mem_excpt = 1'b0;
    aw_cfg    = 0;
    dw_cfg    = 5;
    rd_cfg    = 32'h0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    mem_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    run_vec(vecs[9]);

    cur      = idle_vec;
    instr_id = instr_id + 1;
    mem_en   = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
